// File: rtl/fifo_uart_tx_drain_if.sv
// Read-side port of an 8-bit synchronous FIFO (standard mode, one-cycle read latency).
// The consumer uses the master modport; the FIFO side uses the slave modport.
interface fifo_uart_tx_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en
  );
endinterface

// File: rtl/fifo_uart_tx_drain.sv
// Pops bytes from a synchronous FIFO and serialises each one as an 8N1 UART frame, LSB first.
// The line idles high; a new pop can only start from idle, so frames are spaced 10N+2 cycles.
module fifo_uart_tx_drain #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   en,
  fifo_uart_tx_drain_if.master   fifo,
  output logic                   tx,
  output logic                   busy,
  output logic                   byte_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BaudMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {StIdle, StLatch, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            tx_q;
  logic            busy_q;
  logic            byte_done_q;

  logic pop;
  logic baud_wrap;

  // Reset must win over the pop so a byte is never lost while the block is held in reset.
  assign pop       = (state_q == StIdle) & en & ~fifo.fifo_empty & ~srst;
  assign baud_wrap = (baud_q == BaudMax);

  assign fifo.fifo_rd_en = pop;
  assign tx              = tx_q;
  assign busy            = busy_q;
  assign byte_done       = byte_done_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= StIdle;
      baud_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          baud_q <= '0;
          if (pop) begin
            state_q <= StLatch;
            busy_q  <= 1'b1;
          end
        end
        StLatch: begin
          shreg_q <= fifo.fifo_dout;
          tx_q    <= 1'b0;
          state_q <= StStart;
        end
        StStart: begin
          baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
          if (baud_wrap) begin
            tx_q    <= shreg_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
          if (baud_wrap) begin
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              // tx is registered, so load the next bit while shifting.
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
            end
          end
        end
        StStop: begin
          baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
          // Set one cycle early so the registered pulse lands in the final stop cycle.
          if (baud_q == BaudLast) begin
            byte_done_q <= 1'b1;
          end
          if (baud_wrap) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Directed bench for fifo_uart_tx_drain: a FIFO model feeds two instances (N=4 and N=5),
// and every frame is checked bit by bit against hand-computed 8N1 patterns.
module tb_fifo_uart_tx_drain;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // [9] is the start bit, [0] the stop bit
  } vec_t;

  logic clk;
  logic srst;
  logic en;
  logic tx_a, busy_a, bd_a;
  logic tx_b, busy_b, bd_b;
  bit   sel;

  logic o_tx, o_busy, o_bd, o_rd;

  int nerr;
  int nchecks;
  int cyc;
  int npop_a;
  int npop_b;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  vec_t vecs [5];

  fifo_uart_tx_drain_if ifa ();
  fifo_uart_tx_drain_if ifb ();

  fifo_uart_tx_drain #(.CLKS_PER_BIT(4)) dut_a (
    .clk       (clk),
    .srst      (srst),
    .en        (en),
    .fifo      (ifa),
    .tx        (tx_a),
    .busy      (busy_a),
    .byte_done (bd_a)
  );

  fifo_uart_tx_drain #(.CLKS_PER_BIT(5)) dut_b (
    .clk       (clk),
    .srst      (srst),
    .en        (en),
    .fifo      (ifb),
    .tx        (tx_b),
    .busy      (busy_b),
    .byte_done (bd_b)
  );

  assign o_tx   = sel ? tx_b : tx_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_bd   = sel ? bd_b : bd_a;
  assign o_rd   = sel ? ifb.fifo_rd_en : ifa.fifo_rd_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // One clock: the FIFO model pops on the edge if rd_en was high, dout updates after the edge.
  task automatic tick();
    logic pa, pb;
    pa = ifa.fifo_rd_en;
    pb = ifb.fifo_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    if (pa === 1'b1 && qa.size() > 0) begin
      ifa.fifo_dout = qa.pop_front();
      npop_a++;
    end
    if (pb === 1'b1 && qb.size() > 0) begin
      ifb.fifo_dout = qb.pop_front();
      npop_b++;
    end
    ifa.fifo_empty = (qa.size() == 0);
    ifb.fifo_empty = (qb.size() == 0);
  endtask

  task automatic push_a(input logic [7:0] d);
    qa.push_back(d);
    ifa.fifo_empty = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    qb.push_back(d);
    ifb.fifo_empty = 1'b0;
  endtask

  task automatic wait_pop(input string nm);
    int t;
    t = 0;
    while (o_rd !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    chk({nm, " pop seen"}, o_rd, 1);
  endtask

  // Called in the pop cycle (cycle 0). Walks LATCH, 10 bits of n cycles, and the first idle cycle.
  task automatic check_frame(input string nm, input logic [9:0] frame, input int n,
                             input int drop_bit, input int abort_bit);
    int   bd_bad, busy_bad, rd_bad;
    logic bad;
    bd_bad   = 0;
    busy_bad = 0;
    rd_bad   = 0;
    tick();
    chk({nm, " latch tx"}, o_tx, 1);
    chk({nm, " latch busy"}, o_busy, 1);
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (b == abort_bit && k == 1) begin
          srst = 1'b1;
          tick();
          chk({nm, " reset tx"}, o_tx, 1);
          chk({nm, " reset busy"}, o_busy, 0);
          chk({nm, " reset byte_done"}, o_bd, 0);
          chk({nm, " reset rd_en"}, o_rd, 0);
          srst = 1'b0;
          return;
        end
        if (b == drop_bit && k == 0) en = 1'b0;
        tick();
        if (o_tx !== frame[9-b]) bad = 1'b1;
        if (o_bd !== ((b == 9 && k == n - 1) ? 1'b1 : 1'b0)) bd_bad++;
        if (o_busy !== 1'b1) busy_bad++;
        if (o_rd !== 1'b0) rd_bad++;
      end
      chk($sformatf("%s bit%0d tx wrong", nm, b), {31'd0, bad}, 0);
    end
    chk({nm, " byte_done bad cycles"}, bd_bad, 0);
    chk({nm, " busy low cycles"}, busy_bad, 0);
    chk({nm, " rd_en mid-frame"}, rd_bad, 0);
    tick();
    chk({nm, " idle busy"}, o_busy, 0);
    chk({nm, " idle tx"}, o_tx, 1);
  endtask

  initial begin
    int last;
    int nr;

    vecs[0] = '{data: 8'hA5, frame: 10'b0101001011};
    vecs[1] = '{data: 8'h00, frame: 10'b0000000001};
    vecs[2] = '{data: 8'hFF, frame: 10'b0111111111};
    vecs[3] = '{data: 8'h3C, frame: 10'b0001111001};
    vecs[4] = '{data: 8'h81, frame: 10'b0100000011};

    nerr    = 0;
    nchecks = 0;
    cyc     = 0;
    npop_a  = 0;
    npop_b  = 0;
    sel     = 1'b0;
    srst    = 1'b1;
    en      = 1'b1;
    ifa.fifo_dout  = 8'h00;
    ifb.fifo_dout  = 8'h00;
    ifa.fifo_empty = 1'b1;
    ifb.fifo_empty = 1'b1;

    // Reset held with a byte waiting.
    push_a(vecs[0].data);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset tx", o_tx, 1);
      chk("reset rd_en", o_rd, 0);
      chk("reset busy", o_busy, 0);
      chk("reset byte_done", o_bd, 0);
    end

    // Single byte: pop is combinational as soon as reset drops.
    srst = 1'b0;
    #1;
    chk("release pop immediate", o_rd, 1);
    wait_pop("single");
    check_frame("single A5", vecs[0].frame, 4, -1, -1);
    chk("single rd_en when empty", o_rd, 0);
    repeat (5) tick();
    chk("single pop count", npop_a, 1);

    // Back-to-back frames from the table.
    for (int i = 1; i <= 3; i++) push_a(vecs[i].data);
    last = 0;
    for (int i = 1; i <= 3; i++) begin
      wait_pop($sformatf("b2b%0d", i));
      if (i > 1) chk("b2b pop spacing", cyc - last, 42);
      last = cyc;
      check_frame($sformatf("b2b %02h", vecs[i].data), vecs[i].frame, 4, -1, -1);
    end
    repeat (5) tick();
    chk("b2b idle busy", o_busy, 0);
    chk("b2b pop count", npop_a, 4);

    // Enable gating.
    en = 1'b0;
    push_a(vecs[0].data);
    push_a(vecs[3].data);
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_rd !== 1'b0) nr++;
      tick();
    end
    chk("en=0 no pop strobe", nr, 0);
    chk("en=0 pop count", npop_a, 4);
    en = 1'b1;
    #1;
    chk("en rise pop immediate", o_rd, 1);
    wait_pop("en");
    check_frame("en A5", vecs[0].frame, 4, 3, -1);
    nr = 0;
    for (int i = 0; i < 15; i++) begin
      if (o_rd !== 1'b0) nr++;
      tick();
    end
    chk("en dropped no pop", nr, 0);
    chk("en dropped queue left", qa.size(), 1);
    en = 1'b1;
    wait_pop("en second");
    check_frame("en 3C", vecs[3].frame, 4, -1, -1);
    chk("en pop count", npop_a, 6);

    // Reset at data bit 3; the next byte must go out intact.
    push_a(vecs[0].data);
    push_a(vecs[4].data);
    wait_pop("rst");
    check_frame("rst A5", vecs[0].frame, 4, -1, 4);
    chk("rst queue after abort", qa.size(), 1);
    wait_pop("rst next");
    check_frame("rst 81", vecs[4].frame, 4, -1, -1);
    chk("rst pop count", npop_a, 8);

    // Non-power-of-2 bit time on the N=5 instance.
    sel = 1'b1;
    push_b(vecs[4].data);
    push_b(vecs[4].data);
    wait_pop("n5 first");
    last = cyc;
    check_frame("n5 81 first", vecs[4].frame, 5, -1, -1);
    wait_pop("n5 second");
    chk("n5 pop spacing", cyc - last, 52);
    check_frame("n5 81 second", vecs[4].frame, 5, -1, -1);
    chk("n5 pop count", npop_b, 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
